fft_ram_frame_writer: RTL
=========================

Name: fft_ram_frame_writer

Overview:
Write-side controller for the 1024x32 FFT spectrum RAM (ram_fft) in the oscilloscope path. It accepts one FFT output frame as a valid/ready beat stream with sof/eof markers and drives the RAM write port, optionally in bit-reversed address order. It then holds the buffer until the rd_clk-domain reader hands it back with a release toggle, so a frame is never overwritten while it is being read.

Parameters:
ADDR_WIDTH, 10, RAM write address width.
DATA_WIDTH, 32, beat and RAM word width (re[31:16], im[15:0]; opaque to this block).
FRAME_LEN, 1024, beats per frame. Legal range 2..2**ADDR_WIDTH.
BIT_REV, 0, 1 = write address is the bit-reverse of the ADDR_WIDTH-bit beat index.
AUTO_REARM, 1, 1 = return to ARMED after release; 0 = return to IDLE.

Ports:
wr_clk  in  1  write-domain clock, all logic on posedge.
tb_wr_rst  in  1  reset, asynchronous, active-high; clock wr_clk.
arm  in  1  single-cycle request to start capture; honoured only in IDLE.
s_valid  in  1  beat valid.
s_ready  out  1  beat accept; a beat transfers when s_valid & s_ready.
s_data  in  DATA_WIDTH  beat payload.
s_sof  in  1  first beat of frame.
s_eof  in  1  last beat of frame.
wr_en  out  1  RAM write enable.
wr_addr  out  ADDR_WIDTH  RAM write address.
wr_data  out  DATA_WIDTH  RAM write data.
frame_done  out  1  one-cycle pulse: complete frame is in RAM.
buf_full  out  1  level: buffer owned by reader.
rd_release_tgl  in  1  toggle from rd_clk domain; each edge = buffer released.
frame_err  out  1  sticky framing error flag.
frame_cnt  out  16  completed-frame counter, wraps at 0xFFFF->0.

Behaviour:
- Reset (async assert, sync to wr_clk deassert not required inside block): state IDLE. All outputs 0: s_ready, wr_en, wr_addr, wr_data, frame_done, buf_full, frame_err, frame_cnt. Beat index and synchronizer flops cleared. Reset mid-frame drops the partial frame; RAM contents are not touched.
- States and transitions:
  - IDLE: s_ready=0. arm=1 -> ARMED next cycle, and frame_err is cleared on that edge.
  - ARMED: s_ready=1.
    - Accepted beat without s_sof: discarded.
    - Accepted beat with s_sof: written at index 0, idx<=1, -> WRITE.
    - s_sof & s_eof on the same beat: frame_err<=1, write the beat, stay ARMED.
  - WRITE: s_ready=1. Each accepted beat is written at idx, then idx<=idx+1.
    - s_sof at idx!=0: frame_err<=1, beat written at index 0, idx<=1 (restart).
    - s_eof at idx<FRAME_LEN-1: frame_err<=1, beat written, frame aborted -> ARMED; no frame_done, frame_cnt unchanged.
    - Beat at idx==FRAME_LEN-1: written -> FULL. If s_eof=0 on this beat, frame_err<=1 but the frame still completes.
  - FULL: s_ready=0, buf_full=1.
    - Synchronized release edge -> ARMED (AUTO_REARM=1) or IDLE (AUTO_REARM=0) next cycle; buf_full drops the same edge.
- Write port timing:
  - Registered, latency 1. Beat accepted in cycle N gives wr_en=1, wr_addr, wr_data valid in cycle N+1.
  - wr_addr = idx (BIT_REV=0) or bit-reverse of idx over ADDR_WIDTH bits (BIT_REV=1).
  - wr_en=0 whenever no beat was accepted in the previous cycle. wr_addr/wr_data hold their last value when wr_en=0.
- frame_done: one-cycle pulse in cycle N+2 for a last beat accepted in cycle N (one cycle after the last wr_en). frame_cnt increments on the same edge the pulse is asserted.
- buf_full: rises with frame_done.
- Release CDC: rd_release_tgl passes through a 2-flop synchronizer plus a third flop for edge detect; any edge = release.
  - Release edges seen outside FULL are ignored.
  - A release coinciding with the frame_done cycle is honoured one cycle later (buf_full is high for at least 1 cycle).
- arm outside IDLE: ignored. s_valid is ignored whenever s_ready=0; s_ready is a function of state only (no combinational path from s_valid).
- Throughput: one beat per cycle sustained in WRITE; a frame takes FRAME_LEN cycles at full rate.

Test Plan:
- Reset, arm, 1024 back-to-back beats with s_data=idx, sof on beat 0, eof on beat 1023 -> 1024 writes at wr_addr 0..1023 with matching data; frame_done 1 cycle after last wr_en; frame_cnt=1; buf_full=1; s_ready=0.
- BIT_REV=1, FRAME_LEN=1024: beat index 1 -> wr_addr 512; index 3 -> 768; index 1023 -> 1023. Read back in rd_clk domain -> natural order.
- In FULL, toggle rd_release_tgl (rd_clk 7 ns) -> buf_full falls 3-4 wr_clk cycles later; state ARMED; the next sof frame is written; frame_cnt=2.
- eof at idx 500 -> frame_err=1, no frame_done, state ARMED; next valid frame completes with frame_err still 1 until the next arm in IDLE.
- sof reasserted at idx 300 -> frame_err=1, that beat written at addr 0, and the frame completes 1023 beats later.
- Assert tb_wr_rst at idx 600 -> all outputs 0 immediately; after release, beats are ignored (s_ready=0) until arm.

Source files
------------

// File: rtl/fft_ram_frame_writer.sv
// rtl/fft_ram_frame_writer.sv - write-side frame capture controller for the FFT spectrum RAM
module fft_ram_frame_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int BIT_REV    = 0,
  parameter int AUTO_REARM = 1
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  arm,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  output logic                  buf_full,
  input  logic                  rd_release_tgl,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WRITE, ST_FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [2:0]              r_rel_sync;
  logic                    r_rel_pend;
  logic                    r_done_pend;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_frame_done;
  logic                    r_buf_full;
  logic                    r_frame_err;
  logic [15:0]             r_frame_cnt;

  logic                    w_accept;
  logic                    w_rel_edge;
  logic [ADDR_WIDTH-1:0]   w_idx_eff;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;

  // Ready is a pure decode of the state register; no path from s_valid.
  assign s_ready    = (r_state == ST_ARMED) || (r_state == ST_WRITE);
  assign w_accept   = s_valid & s_ready;
  // Bits [1] and [2] are the second and third synchronizer stages.
  assign w_rel_edge = r_rel_sync[1] ^ r_rel_sync[2];

  // Beat index for the current beat (sof always restarts at 0) and its RAM address.
  always_comb begin
    w_idx_eff = s_sof ? '0 : r_idx;
    w_wr_addr = w_idx_eff;
    if (BIT_REV != 0) begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
        w_wr_addr[i] = w_idx_eff[ADDR_WIDTH-1-i];
      end
    end
  end

  // Frame capture FSM, registered write port, completion pulse and release handshake.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_rel_sync   <= '0;
      r_rel_pend   <= 1'b0;
      r_done_pend  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_buf_full   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_rel_sync   <= {r_rel_sync[1:0], rd_release_tgl};
      r_wr_en      <= 1'b0;
      r_frame_done <= r_done_pend;
      r_done_pend  <= 1'b0;
      // The last RAM write happened one cycle ago; announce the frame now.
      if (r_done_pend) begin
        r_buf_full  <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state     <= ST_ARMED;
            r_frame_err <= 1'b0;
          end
        end

        ST_ARMED, ST_WRITE: begin
          // In ARMED only a start-of-frame beat is kept; anything else is dropped.
          if (w_accept && (s_sof || (r_state == ST_WRITE))) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= s_data;
            if (s_sof && (r_state == ST_WRITE)) begin
              r_frame_err <= 1'b1;
            end
            if (w_idx_eff == LAST_IDX) begin
              r_state     <= ST_FULL;
              r_done_pend <= 1'b1;
              if (!s_eof) begin
                r_frame_err <= 1'b1;
              end
            end else if (s_eof) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_ARMED;
            end else begin
              r_idx   <= w_idx_eff + ADDR_WIDTH'(1);
              r_state <= ST_WRITE;
            end
          end
        end

        ST_FULL: begin
          // A release that lands before buf_full is up is remembered, so the
          // reader always sees buf_full high for at least one cycle.
          if (r_buf_full && (w_rel_edge || r_rel_pend)) begin
            r_buf_full <= 1'b0;
            r_rel_pend <= 1'b0;
            r_state    <= (AUTO_REARM != 0) ? ST_ARMED : ST_IDLE;
          end else if (w_rel_edge) begin
            r_rel_pend <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign buf_full   = r_buf_full;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;

endmodule
